seq_divider: RTL and testbench
==============================

# seq_divider

Sequential signed 32-bit divider for the Mini-SRC datapath, the iterative counterpart of the combinational adder/subtractor: it computes quotient and remainder by repeated shift-and-subtract, one quotient bit per clock. The control unit drives it for DIV, loading LO from `quotient` and HI from `remainder` when `done` pulses. It uses a start/busy/done handshake so the control FSM can stall for the fixed latency.

## Interface
- `WIDTH`, 32, operand and result width. Only 32 is verified.
- `clock`  in  1  single clock; all state updates on the rising edge
- `clear_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request a division; accepted only when `busy`=0
- `dividend`  in  32  signed two's-complement numerator, sampled on the accepted `start` edge
- `divisor`  in  32  signed two's-complement denominator, sampled on the accepted `start` edge
- `busy`  out  1  high while a division is in progress
- `done`  out  1  one-cycle pulse; results valid from this cycle on
- `quotient`  out  32  signed quotient, truncated toward zero (LO)
- `remainder`  out  32  signed remainder, same sign as the dividend (HI)
- `div_by_zero`  out  1  set with `done` when the divisor was 0; held with the results

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: `start`=1 captures |dividend| into the quotient shift register and |divisor| into the divisor register. It also captures sign(dividend), sign(dividend)^sign(divisor), and divisor==0. It clears the 33-bit partial remainder and the 6-bit iteration counter, then goes to CALC.
- CALC, one step per cycle, 32 steps:
  - Shift {rem, q} left by 1.
  - trial = rem_shifted − {1'b0, |divisor|} (33-bit).
  - If trial ≥ 0: rem = trial and q[0] = 1; otherwise keep rem_shifted and set q[0] = 0.
  - The counter increments each step. After step 32 the FSM goes to FIX.
- FIX: applies signs and special cases, then loads the output registers and goes to DONE.
  - quotient = q negated if the quotient sign is 1.
  - remainder = rem[31:0] negated if the dividend sign is 1.
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = original dividend, `div_by_zero`=1.
  - 0x80000000 / −1: quotient = 0x80000000, remainder = 0. The magnitude 2^31 is handled through the 33-bit path with no special logic, but the result must match.
- DONE: `done`=1 for this cycle only, then the FSM goes to IDLE. A `start` in the DONE cycle is accepted and goes straight to CALC.
- Outputs hold their value until the next FIX. Inputs changing after the accepted `start` have no effect.
- `start` while `busy`=1 is ignored, with no queuing and no restart.

## Timing
- Reset (`clear_n`=0, asynchronous, at any time including mid-CALC):
  - State goes to IDLE.
  - `busy`, `done`, `quotient`, `remainder`, `div_by_zero` and all internal registers go to 0.
  - No `done` is produced for the aborted operation.
- `start` accepted at edge T:
  - `busy`=1 from T through the FIX cycle (edges T+1 … T+33).
  - `done`=1 during cycle T+34 to T+35, with `busy`=0 in that cycle.
- Latency is fixed at 34 cycles from accepted `start` to `done`, independent of operand values, including divide-by-zero.
- `quotient`, `remainder` and `div_by_zero` change only at the edge entering DONE.
- Arithmetic: the magnitude of −2^31 is the unsigned value 0x80000000, kept in 32 bits. All sign negation is two's complement, modulo 2^32.

## Test plan
- 100 / 7 → `done` exactly 34 cycles after `start`; quotient 14 (0x0000000E), remainder 2, `div_by_zero`=0.
- −100 / 7 → quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2). 100 / −7 → quotient 0xFFFFFFF2, remainder 2. −100 / −7 → quotient 14, remainder 0xFFFFFFFE.
- 5 / 0 → quotient 0xFFFFFFFF, remainder 5, `div_by_zero`=1. A following 9 / 3 gives quotient 3, remainder 0, `div_by_zero`=0.
- 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. 0x80000000 / 1 → quotient 0x80000000, remainder 0. 0x7FFFFFFF / 0x80000000 → quotient 0, remainder 0x7FFFFFFF.
- Handshake:
  - `start` with 50 / 5, then `start` with 1 / 1 at cycle 10 while busy: the second request is ignored; results are 10 / 0 at cycle 34.
  - `start` held high through the DONE cycle launches a new division immediately, and `busy` is high the next cycle.
- Pull `clear_n` low asynchronously at cycle 12 of a division: all outputs go to 0 immediately and no `done` appears. After release, 21 / 4 → quotient 5, remainder 1 in 34 cycles.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential signed divider: restoring shift-and-subtract, one quotient bit per clock.
// Start/busy/done handshake with a fixed 34-cycle latency from accepted start to done.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_q, w_q_nxt;
    logic [WIDTH:0]     r_rem, w_rem_nxt;
    logic [WIDTH-1:0]   r_dvs, w_dvs_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_qsign, w_qsign_nxt;
    logic               r_rsign, w_rsign_nxt;
    logic               r_dz, w_dz_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [WIDTH-1:0]   r_quot, w_quot_nxt;
    logic [WIDTH-1:0]   r_remo, w_remo_nxt;
    logic               r_dzo, w_dzo_nxt;

    logic [WIDTH-1:0]   w_abs_dvd, w_abs_dvs;
    logic [WIDTH:0]     w_shift, w_trial;

    // Magnitude of -2^31 wraps to 0x80000000, which the unsigned datapath handles directly
    assign w_abs_dvd = dividend[WIDTH-1] ? (-dividend) : dividend;
    assign w_abs_dvs = divisor[WIDTH-1]  ? (-divisor)  : divisor;
    assign w_shift   = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_rem_nxt   = r_rem;
        w_dvs_nxt   = r_dvs;
        w_cnt_nxt   = r_cnt;
        w_qsign_nxt = r_qsign;
        w_rsign_nxt = r_rsign;
        w_dz_nxt    = r_dz;
        w_quot_nxt  = r_quot;
        w_remo_nxt  = r_remo;
        w_dzo_nxt   = r_dzo;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_q_nxt     = w_abs_dvd;
                    w_dvs_nxt   = w_abs_dvs;
                    w_rem_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_rsign_nxt = dividend[WIDTH-1];
                    w_qsign_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    w_dz_nxt    = (divisor == '0);
                    w_state_nxt = S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                // Extra cycle after the last step keeps latency at 34 edges
                if (r_cnt == LAST_STEP) begin
                    w_state_nxt = S_FIX;
                end else begin
                    if (!w_trial[WIDTH]) begin
                        w_rem_nxt = w_trial;
                        w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        w_rem_nxt = w_shift;
                        w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
                    end
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_FIX: begin
                w_quot_nxt = r_qsign ? (-r_q) : r_q;
                // With a zero divisor every trial succeeds, so rem already holds |dividend|
                w_remo_nxt = r_rsign ? (-r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
                w_dzo_nxt  = r_dz;
                if (r_dz) begin
                    w_quot_nxt = '1;
                end
                w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dzo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_rem   <= w_rem_nxt;
            r_dvs   <= w_dvs_nxt;
            r_cnt   <= w_cnt_nxt;
            r_qsign <= w_qsign_nxt;
            r_rsign <= w_rsign_nxt;
            r_dz    <= w_dz_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_quot  <= w_quot_nxt;
            r_remo  <= w_remo_nxt;
            r_dzo   <= w_dzo_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dzo;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes expected results, monitor checks on done.
module tb_seq_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          t;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare every done pulse against the oldest expected entry
    always begin
        @(posedge clock);
        #1;
        if (clear_n && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient",    quotient,              e.q);
                check("remainder",   remainder,             e.r);
                check("div_by_zero", 32'(div_by_zero),      32'(e.dz));
                check("latency",     32'(cyc - e.t),        32'd34);
                check("busy_in_done", 32'(busy),            32'd0);
            end
        end
    end

    task automatic wait_empty();
        for (int i = 0; i < 45 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL timeout: got no done expected done within 45 cycles (cycle %0d)", cyc);
            sb.delete();
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
        @(negedge clock);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clock);
        #1;
        sb.push_back('{eq, er, edz, cyc});
        start = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        wait_empty();
    endtask

    initial begin
        int t0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem",  remainder, 32'd0);
        check("rst_dz",   32'(div_by_zero), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;

        issue(32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        issue(-32'sd100,      32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0);
        issue(32'd100,        -32'sd7,        32'hFFFFFFF2,   32'd2,          1'b0);
        issue(-32'sd100,      -32'sd7,        32'd14,         32'hFFFFFFFE,   1'b0);
        issue(32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1);
        issue(32'd9,          32'd3,          32'd3,          32'd0,          1'b0);
        issue(-32'sd5,        32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1);
        issue(32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
        issue(32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0);
        issue(32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0);

        // A start while busy must be ignored
        @(negedge clock);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clock);
        #1;
        t0 = cyc;
        sb.push_back('{32'd10, 32'd0, 1'b0, t0});
        start = 1'b0;
        while (cyc < t0 + 9) @(negedge clock);
        start = 1'b1; dividend = 32'd1; divisor = 32'd1;
        @(negedge clock);
        start = 1'b0;
        wait_empty();

        // Start held through DONE launches the next division immediately
        @(negedge clock);
        start = 1'b1; dividend = 32'd6; divisor = 32'd2;
        @(posedge clock);
        #1;
        sb.push_back('{32'd3, 32'd0, 1'b0, cyc});
        dividend = 32'd8; divisor = 32'd2;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) break;
        end
        sb.push_back('{32'd4, 32'd0, 1'b0, cyc + 1});
        @(posedge clock);
        #1;
        check("busy_after_done_start", 32'(busy), 32'd1);
        start = 1'b0;
        wait_empty();

        // Asynchronous clear mid-CALC aborts with no done
        @(negedge clock);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clock);
        #3;
        clear_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quot", quotient, 32'd0);
        check("abort_rem",  remainder, 32'd0);
        check("abort_dz",   32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        repeat (40) @(negedge clock);
        issue(32'd21, 32'd4, 32'd5, 32'd1, 1'b0);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
